// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM states, latched op, SRAM data width.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
   typedef enum logic {OP_RD, OP_WR} op_t;

   localparam int unsigned SRAM_DW = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1 and flags the final cycle of a half-word access.
module sram_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_last_c
);

   localparam int unsigned CNT_W = $clog2(WAIT_CYCLES);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_last_c = (r_cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage controller for a 16-bit async SRAM: each 32-bit load/store becomes two
// half-word accesses (low half first) while ready stays low to freeze the pipeline.
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 4,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned ADDR_W      = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               ready,
   output logic [ADDR_W-1:0]  sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n
);

   localparam int unsigned WORD_W = ADDR_W - 1;

   state_t            r_state;
   state_t            w_state_nxt;
   op_t               r_op;
   op_t               w_op_nxt;
   logic [31:0]       r_rdata;
   logic              w_req;
   logic              w_last;
   logic              w_cnt_clr;
   logic              w_cnt_en;
   logic              w_cap_lo;
   logic              w_cap_hi;
   logic [WORD_W-1:0] w_word;

   assign w_req  = mem_r_en | mem_w_en;
   // Offset wraps in 32 bits; byte-lane bits and bits above the SRAM range drop out.
   assign w_word = WORD_W'((addr - 32'(BASE_ADDR)) >> 2);
   assign rdata  = r_rdata;

   sram_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_cnt_clr),
      .i_en     (w_cnt_en),
      .o_last_c (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_op    <= OP_RD;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         if (w_cap_lo) r_rdata[15:0]  <= sram_dq_in;
         if (w_cap_hi) r_rdata[31:16] <= sram_dq_in;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      w_cnt_clr   = 1'b0;
      w_cnt_en    = 1'b0;
      w_cap_lo    = 1'b0;
      w_cap_hi    = 1'b0;
      case (r_state)
         IDLE: begin
            ready     = ~w_req;
            w_cnt_clr = 1'b1;
            if (w_req) begin
               w_state_nxt = LOW;
               w_op_nxt    = mem_w_en ? OP_WR : OP_RD;
            end
         end
         LOW, HIGH: begin
            w_cnt_en  = 1'b1;
            sram_addr = {w_word, (r_state == HIGH)};
            if (r_op == OP_WR) begin
               // Strobe released on the last cycle so address and data are held past we_n rise.
               sram_dq_oe  = 1'b1;
               sram_we_n   = w_last;
               sram_dq_out = (r_state == HIGH) ? wdata[31:16] : wdata[15:0];
            end else begin
               w_cap_lo = w_last && (r_state == LOW);
               w_cap_hi = w_last && (r_state == HIGH);
            end
            if (w_last) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = (r_state == LOW) ? HIGH : DONE;
            end
         end
         DONE: begin
            ready       = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule
